perf_counter_readout_ctrl: RTL and testbench



---
 rtl/perf_counter_readout_ctrl.sv | 125 ++++++++++++
 tb/tb_perf_counter_readout_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_readout_ctrl.sv
// Snapshots the MAC perf counter bank and streams it out as lo/hi 32-bit word pairs (PERF_CLEAR_ON_READ_EN adds clear-on-read).
// Latency: first word valid the cycle after start, then one word per cycle at full throughput.
// Backpressure: out_ready low holds the presented word stable; abort drops the readout on the next edge.
module perf_counter_readout_ctrl #(
    parameter int NUM_COUNTERS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [64*NUM_COUNTERS-1:0] counters,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_data,
    output logic [2:0]                out_index,
    output logic                      out_hi,
    output logic                      out_last,
    output logic                      clear_req
);

    localparam logic [3:0] LAST_K = 4'(2*NUM_COUNTERS-1);

`ifdef PERF_CLEAR_ON_READ_EN
    typedef enum logic [1:0] {IDLE, EMIT, CLEAR} state_t;
`else
    typedef enum logic [0:0] {IDLE, EMIT} state_t;
`endif

    state_t      state, state_nxt;
    logic [3:0]  word_k, word_k_nxt;
    logic        snap;
    logic        xfer;
    logic [63:0] shadow [NUM_COUNTERS];
    logic [63:0] sel_word;

    assign out_valid = (state == EMIT);
    assign busy      = (state != IDLE);
    assign xfer      = out_valid && out_ready;
    assign out_index = word_k[3:1];
    assign out_hi    = word_k[0];
    assign out_last  = out_valid && (word_k == LAST_K);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            word_k <= '0;
        end else begin
            state  <= state_nxt;
            word_k <= word_k_nxt;
        end
    end

    // abort wins over a same-edge handshake, so an aborted last word never reaches CLEAR
    always_comb begin
        state_nxt  = state;
        word_k_nxt = word_k;
        snap       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    snap       = 1'b1;
                    state_nxt  = EMIT;
                    word_k_nxt = '0;
                end
            end
            EMIT: begin
                if (abort) begin
                    state_nxt  = IDLE;
                    word_k_nxt = '0;
                end else if (xfer) begin
                    if (word_k == LAST_K) begin
                        word_k_nxt = '0;
`ifdef PERF_CLEAR_ON_READ_EN
                        state_nxt  = CLEAR;
`else
                        state_nxt  = IDLE;
`endif
                    end else begin
                        word_k_nxt = word_k + 4'd1;
                    end
                end
            end
`ifdef PERF_CLEAR_ON_READ_EN
            CLEAR: begin
                state_nxt = IDLE;
            end
`endif
            default: begin
                state_nxt  = IDLE;
                word_k_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                shadow[i] <= '0;
            end
        end else if (snap) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                shadow[i] <= counters[64*i +: 64];
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (word_k[3:1] == 3'(i)) begin
                sel_word = shadow[i];
            end
        end
    end

    assign out_data = !out_valid ? 32'd0 : (word_k[0] ? sel_word[63:32] : sel_word[31:0]);

`ifdef PERF_CLEAR_ON_READ_EN
    assign clear_req = (state == CLEAR);
`else
    assign clear_req = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_readout_ctrl.sv
// Directed bench for perf_counter_readout_ctrl: cycle table for readout/backpressure/start-while-busy,
// hand sequences for atomicity, abort/restart and asynchronous reset.
module tb_perf_counter_readout_ctrl;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [64*N-1:0] counters;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           out_ready = 1'b0;
    logic           busy, out_valid, out_hi, out_last, clear_req;
    logic [31:0]    out_data;
    logic [2:0]     out_index;

    perf_counter_readout_ctrl #(.NUM_COUNTERS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .counters  (counters),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_hi    (out_hi),
        .out_last  (out_last),
        .clear_req (clear_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic start;
        logic rdy;
        logic abrt;
        logic e_busy;
        logic e_valid;
        logic e_clr;
        int   e_k;
    } vec_t;

    vec_t        vec[$];
    int          tests = 0;
    int          fails = 0;
    int          clr_count = 0;
    int          clr0;
    int          nwords;
    logic [31:0] words [16];

    always @(posedge clk) if (clear_req) clr_count++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic s, input logic r, input logic a,
                        input logic b, input logic v, input logic c, input int k);
        vec_t t;
        t.start = s; t.rdy = r; t.abrt = a;
        t.e_busy = b; t.e_valid = v; t.e_clr = c; t.e_k = k;
        vec.push_back(t);
    endtask

    task automatic set_counters(input logic [31:0] base);
        for (int i = 0; i < N; i++) begin
            counters[64*i +: 64] = {base + 32'(2*i+1), base + 32'(2*i)};
        end
    endtask

    // Samples every accepted word for a fixed window starting at a negedge.
    task automatic collect();
        nwords = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (out_valid && out_ready && nwords < 16) begin
                words[nwords] = out_data;
                nwords++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [39:0] act_v, exp_v;
        logic [31:0] kk;

        // A: basic readout, word k carries value k
        push(1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) push(0, 1, 0, 1, 1, 0, k);
`ifdef PERF_CLEAR_ON_READ_EN
        push(0, 1, 0, 1, 0, 1, 0);
`endif
        push(0, 1, 0, 0, 0, 0, 0);
        // B: backpressure on word 2, start while busy and on the last transfer edge
        push(1, 1, 0, 0, 0, 0, 0);
        push(0, 1, 0, 1, 1, 0, 0);
        push(0, 1, 0, 1, 1, 0, 1);
        push(0, 0, 0, 1, 1, 0, 2);
        push(1, 0, 0, 1, 1, 0, 2);
        push(0, 0, 0, 1, 1, 0, 2);
        push(0, 1, 0, 1, 1, 0, 2);
        for (int k = 3; k < 9; k++) push(k == 5, 1, 0, 1, 1, 0, k);
        push(1, 1, 0, 1, 1, 0, 9);
`ifdef PERF_CLEAR_ON_READ_EN
        push(0, 1, 0, 1, 0, 1, 0);
`endif
        push(0, 1, 0, 0, 0, 0, 0);
        push(0, 1, 0, 0, 0, 0, 0);

        set_counters(32'd0);
        #12;
        check("reset_state", 64'({busy, out_valid, out_last, out_hi, out_index, out_data, clear_req}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vec[i]) begin
            @(negedge clk);
            start = vec[i].start;
            out_ready = vec[i].rdy;
            abort = vec[i].abrt;
            #1;
            kk = 32'(vec[i].e_k);
            if (vec[i].e_valid) begin
                act_v = {busy, out_valid, clear_req, out_last, out_hi, out_index, out_data};
                exp_v = {1'b1, 1'b1, 1'b0, (vec[i].e_k == 9), kk[0], kk[3:1], kk};
            end else begin
                act_v = {busy, out_valid, clear_req, 37'd0};
                exp_v = {vec[i].e_busy, 1'b0, vec[i].e_clr, 37'd0};
            end
            if (act_v !== exp_v) $display("  row %0d", i);
            check("table_row", 64'(act_v), 64'(exp_v));
        end
        @(negedge clk);
        start = 1'b0;

        // C: atomicity across a lo->hi carry in counter 2
        counters[64*2 +: 64] = 64'h0000_0000_FFFF_FFFF;
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        counters[64*2 +: 64] = 64'h0000_0001_0000_0000;
        collect();
        check("atomic_count", 64'(nwords), 64'd10);
        check("atomic_lo", 64'(words[4]), 64'hFFFF_FFFF);
        check("atomic_hi", 64'(words[5]), 64'h0000_0000);
        check("atomic_last", 64'(words[9]), 64'd9);

        // D: abort on word 4, then restart with fresh values
        set_counters(32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clr0 = clr_count;
        repeat (4) @(negedge clk);
        #1;
        check("abort_pre_word", 64'({out_valid, out_index, out_hi, out_data}), 64'({1'b1, 3'd2, 1'b0, 32'd4}));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_drop", 64'({busy, out_valid}), 64'd0);
        set_counters(32'h100);
        @(negedge clk);
        check("abort_no_clear", 64'(clr_count), 64'(clr0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("restart_word0", 64'({out_valid, out_index, out_hi, out_data}), 64'({1'b1, 3'd0, 1'b0, 32'h100}));
        @(negedge clk);
        start = 1'b0;
        collect();
        // the first word was already accepted before collect() began
        check("restart_count", 64'(nwords), 64'd9);
        check("restart_last", 64'(words[8]), 64'h109);
        check("restart_idle", 64'(busy), 64'd0);

        // E: asynchronous reset in the middle of a readout
        set_counters(32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_reset_word", 64'(out_data), 64'd3);
        clr0 = clr_count;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'({busy, out_valid, out_last, out_hi, out_index, out_data, clear_req}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("reset_no_clear", 64'(clr_count), 64'(clr0));
        check("reset_idle", 64'({busy, out_valid}), 64'd0);
`ifndef PERF_CLEAR_ON_READ_EN
        check("clear_never", 64'(clr_count), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
